// File: rtl/link_scheduler.sv
// link_scheduler: sequences one encrypted-link transfer of WORDS words.
// Loads a common seed into both SSRGs, fetches each word, then gates the key
// generators and transmitter for BITS cycles, with GAP idle cycles between words.
// Optional feature macro: LINK_SCHED_RESEED_EN (reload key_seed at every FETCH).
// All outputs are registered Moore outputs.
module link_scheduler #(
  parameter int unsigned WORDS = 16,
  parameter int unsigned BITS  = 8,
  parameter int unsigned GAP   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] seed,
  output logic       busy,
  output logic       src_ena,
  output logic [3:0] word_addr,
  output logic       key_load,
  output logic [7:0] key_seed,
  output logic       key_ena,
  output logic       tx_ena,
  output logic [2:0] bit_idx,
  output logic       frame_sync,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFetch,
    StShift,
    StGap,
    StFinish
  } state_e;

  localparam logic [3:0] WordLast = 4'(WORDS - 1);
  localparam logic [2:0] BitLast  = 3'(BITS - 1);
  localparam logic [2:0] GapLast  = (GAP == 0) ? 3'd0 : 3'(GAP - 1);
  localparam bit         HasGap   = (GAP != 0);

`ifdef LINK_SCHED_RESEED_EN
  // Every word restarts the key stream from the latched seed.
  localparam bit ReseedEn = 1'b1;
`else
  // Key stream runs continuously across the whole transfer.
  localparam bit ReseedEn = 1'b0;
`endif

  state_e     state_q;
  logic [2:0] gap_cnt_q;

  // Sequencer FSM; each output register holds its value for the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      gap_cnt_q  <= 3'd0;
      busy       <= 1'b0;
      src_ena    <= 1'b0;
      word_addr  <= 4'd0;
      key_load   <= 1'b0;
      key_seed   <= 8'd0;
      key_ena    <= 1'b0;
      tx_ena     <= 1'b0;
      bit_idx    <= 3'd0;
      frame_sync <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      // Strobes are single-cycle unless the entered state re-asserts them.
      src_ena    <= 1'b0;
      key_load   <= 1'b0;
      key_ena    <= 1'b0;
      tx_ena     <= 1'b0;
      frame_sync <= 1'b0;
      done       <= 1'b0;

      if (state_q != StIdle && abort) begin
        // Abort wins over every other transition; done is never pulsed.
        state_q   <= StIdle;
        busy      <= 1'b0;
        err       <= 1'b1;
        word_addr <= 4'd0;
        bit_idx   <= 3'd0;
        gap_cnt_q <= 3'd0;
      end else begin
        case (state_q)
          StIdle: begin
            if (start && !abort) begin
              state_q   <= StLoad;
              busy      <= 1'b1;
              key_seed  <= seed;
              err       <= 1'b0;
              key_load  <= 1'b1;
              word_addr <= 4'd0;
            end
          end
          StLoad: begin
            state_q  <= StFetch;
            src_ena  <= 1'b1;
            key_load <= ReseedEn;
            bit_idx  <= 3'd0;
          end
          StFetch: begin
            state_q    <= StShift;
            key_ena    <= 1'b1;
            tx_ena     <= 1'b1;
            frame_sync <= 1'b1;
          end
          StShift: begin
            if (bit_idx == BitLast) begin
              bit_idx <= 3'd0;
              if (word_addr == WordLast) begin
                state_q <= StFinish;
                done    <= 1'b1;
              end else if (HasGap) begin
                state_q   <= StGap;
                gap_cnt_q <= 3'd0;
              end else begin
                state_q   <= StFetch;
                word_addr <= word_addr + 4'd1;
                src_ena   <= 1'b1;
                key_load  <= ReseedEn;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              key_ena <= 1'b1;
              tx_ena  <= 1'b1;
            end
          end
          StGap: begin
            if (gap_cnt_q == GapLast) begin
              state_q   <= StFetch;
              gap_cnt_q <= 3'd0;
              word_addr <= word_addr + 4'd1;
              src_ena   <= 1'b1;
              key_load  <= ReseedEn;
              bit_idx   <= 3'd0;
            end else begin
              gap_cnt_q <= gap_cnt_q + 3'd1;
            end
          end
          StFinish: begin
            state_q   <= StIdle;
            busy      <= 1'b0;
            word_addr <= 4'd0;
          end
          default: begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
